// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - queued instruction fetch stage between the core and the instruction cache
// Define FETCH_LINE_BUFFER_EN to serve sequential fetches from the last returned cache line.
module fetch_unit #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int LINE_WIDTH  = 128,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [PC_WIDTH-1:0]    boot_addr,
  input  logic                   take_branch,
  input  logic [PC_WIDTH-1:0]    branch_pc,
  input  logic                   stall_fetch,
  output logic                   decode_instr_valid,
  output logic [INSTR_WIDTH-1:0] decode_instr_data,
  output logic [PC_WIDTH-1:0]    decode_instr_pc,
  output logic                   icache_req_valid,
  output logic [PC_WIDTH-1:0]    icache_req_addr,
  input  logic                   icache_ready,
  input  logic                   icache_rsp_valid,
  input  logic [LINE_WIDTH-1:0]  icache_rsp_data
);

  localparam int OFF = $clog2(LINE_WIDTH / 8);
  localparam int QW  = $clog2(QUEUE_DEPTH);

  typedef enum logic [1:0] {FETCH, WAIT, DRAIN} state_t;

  state_t state;
  state_t state_next;

  logic [PC_WIDTH-1:0]    fetch_pc;
  logic [PC_WIDTH-1:0]    q_pc    [QUEUE_DEPTH];
  logic [INSTR_WIDTH-1:0] q_instr [QUEUE_DEPTH];
  logic [QW-1:0]          head;
  logic [QW-1:0]          tail;
  logic [QW:0]            count;

  logic                   full;
  logic                   req;
  logic                   hit;
  logic                   rsp_push;
  logic                   push;
  logic                   pop;
  logic                   lb_match;
  logic [INSTR_WIDTH-1:0] lb_word;
  logic [INSTR_WIDTH-1:0] rsp_word;
  logic [INSTR_WIDTH-1:0] push_instr;

  function automatic logic [INSTR_WIDTH-1:0] select_word(input logic [LINE_WIDTH-1:0] line,
                                                         input logic [OFF-1:0] byte_off);
    logic [OFF-1:0] idx;
    idx = byte_off >> 2;
    return INSTR_WIDTH'(line >> (INSTR_WIDTH * int'(idx)));
  endfunction

  assign full     = (count == (QW+1)'(QUEUE_DEPTH));
  assign rsp_word = select_word(icache_rsp_data, fetch_pc[OFF-1:0]);

`ifdef FETCH_LINE_BUFFER_EN
  logic                    lb_valid;
  logic [PC_WIDTH-OFF-1:0] lb_tag;
  logic [LINE_WIDTH-1:0]   lb_data;

  // A redirect does not invalidate the line: instruction memory is read-only.
  always_ff @(posedge clock) begin
    if (reset) begin
      lb_valid <= 1'b0;
    end else if (rsp_push) begin
      lb_valid <= 1'b1;
      lb_tag   <= fetch_pc[PC_WIDTH-1:OFF];
      lb_data  <= icache_rsp_data;
    end
  end

  assign lb_match = lb_valid && (lb_tag == fetch_pc[PC_WIDTH-1:OFF]);
  assign lb_word  = select_word(lb_data, fetch_pc[OFF-1:0]);
`else
  assign lb_match = 1'b0;
  assign lb_word  = '0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH: if (req && icache_ready) state_next = WAIT;
      WAIT: begin
        if (icache_rsp_valid) begin
          state_next = FETCH;
        end else if (take_branch) begin
          state_next = DRAIN;
        end
      end
      // The stale response retires the drain even if another redirect lands with it.
      DRAIN: if (icache_rsp_valid) state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    req      = 1'b0;
    hit      = 1'b0;
    rsp_push = 1'b0;
    case (state)
      FETCH: begin
        if (!full && !take_branch) begin
          if (lb_match) begin
            hit = 1'b1;
          end else begin
            req = 1'b1;
          end
        end
      end
      WAIT:    rsp_push = icache_rsp_valid && !take_branch;
      default: ;
    endcase
  end

  assign push       = hit || rsp_push;
  assign push_instr = hit ? lb_word : rsp_word;
  assign pop        = decode_instr_valid && !stall_fetch && !take_branch;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= boot_addr;
    end else if (take_branch) begin
      fetch_pc <= branch_pc & ~PC_WIDTH'(3);
    end else if (push) begin
      fetch_pc <= fetch_pc + PC_WIDTH'(4);
    end
  end

  always_ff @(posedge clock) begin
    if (reset || take_branch) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        q_pc[tail]    <= fetch_pc;
        q_instr[tail] <= push_instr;
        tail          <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign decode_instr_valid = !reset && (count != '0);
  assign decode_instr_data  = decode_instr_valid ? q_instr[head] : '0;
  assign decode_instr_pc    = decode_instr_valid ? q_pc[head] : '0;
  assign icache_req_valid   = req && !reset;
  assign icache_req_addr    = fetch_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized bench for fetch_unit against a transaction-level fetch model
// Extra occupancy checks apply when FETCH_LINE_BUFFER_EN is undefined.
module tb_fetch_unit;

  localparam int DEPTH = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic [31:0]  boot_addr;
  logic         take_branch;
  logic [31:0]  branch_pc;
  logic         stall_fetch;
  logic         decode_instr_valid;
  logic [31:0]  decode_instr_data;
  logic [31:0]  decode_instr_pc;
  logic         icache_req_valid;
  logic [31:0]  icache_req_addr;
  logic         icache_ready;
  logic         icache_rsp_valid;
  logic [127:0] icache_rsp_data;

  fetch_unit #(.PC_WIDTH(32), .INSTR_WIDTH(32), .LINE_WIDTH(128), .QUEUE_DEPTH(DEPTH)) dut (
    .clock              (clock),
    .reset              (reset),
    .boot_addr          (boot_addr),
    .take_branch        (take_branch),
    .branch_pc          (branch_pc),
    .stall_fetch        (stall_fetch),
    .decode_instr_valid (decode_instr_valid),
    .decode_instr_data  (decode_instr_data),
    .decode_instr_pc    (decode_instr_pc),
    .icache_req_valid   (icache_req_valid),
    .icache_req_addr    (icache_req_addr),
    .icache_ready       (icache_ready),
    .icache_rsp_valid   (icache_rsp_valid),
    .icache_rsp_data    (icache_rsp_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    int          ep;
    int          due;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] acc_log[$];
  logic [31:0] pop_log[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          lat_lo = 1;
  int          lat_hi = 1;
  int          first_valid_cyc = -1;
  int          q_count = 0;
  logic [31:0] exp_pc = '0;
  logic [31:0] fetch_model = '0;
  logic        obs_req_valid;
  logic [31:0] obs_req_addr;
  logic        obs_valid;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {2'b00, a[31:2]};
    return (w * 32'h9E3779B1) ^ 32'h5EED_1234;
  endfunction

  function automatic logic [127:0] make_line(input logic [31:0] a);
    logic [127:0] line;
    logic [31:0]  base;
    base = {a[31:4], 4'b0000};
    for (int i = 0; i < 4; i++) line[32*i +: 32] = mem_word(base + 32'(4 * i));
    return line;
  endfunction

  // One clock cycle: drive the cache response, check outputs, advance the model.
  task automatic step();
    logic rsp_live;
    logic popped;
    logic accepted;
    rsp_live         = 1'b0;
    icache_rsp_valid = 1'b0;
    icache_rsp_data  = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      icache_rsp_valid = 1'b1;
      icache_rsp_data  = make_line(pend[0].addr);
    end
    #1;
    obs_req_valid = icache_req_valid;
    obs_req_addr  = icache_req_addr;
    obs_valid     = decode_instr_valid;
    if (reset) begin
      check("rst_dec_valid", decode_instr_valid, 0);
      check("rst_dec_data", decode_instr_data, 0);
      check("rst_dec_pc", decode_instr_pc, 0);
      check("rst_req_valid", icache_req_valid, 0);
    end else begin
      if (decode_instr_valid) begin
        check("dec_pc", decode_instr_pc, exp_pc);
        check("dec_data", decode_instr_data, mem_word(exp_pc));
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
`ifndef FETCH_LINE_BUFFER_EN
      check("dec_valid", decode_instr_valid, q_count != 0);
      if (q_count == DEPTH) check("full_req_idle", icache_req_valid, 0);
`endif
    end

    if (icache_rsp_valid) begin
      rsp_live = (pend[0].ep == epoch) && !take_branch && !reset;
      void'(pend.pop_front());
    end
    popped   = decode_instr_valid && !stall_fetch && !take_branch && !reset;
    accepted = icache_req_valid && icache_ready && !reset;
    if (accepted) begin
      check("one_outstanding", pend.size(), 0);
      check("req_align", icache_req_addr[1:0], 0);
`ifndef FETCH_LINE_BUFFER_EN
      check("req_addr", icache_req_addr, fetch_model);
`endif
      acc_log.push_back(icache_req_addr);
      pend.push_back('{addr: icache_req_addr, ep: epoch, due: cyc + int'($urandom_range(lat_hi, lat_lo))});
    end
    if (popped) begin
      pop_log.push_back(decode_instr_pc);
      exp_pc = exp_pc + 32'd4;
    end
    if (reset) begin
      pend.delete();
      epoch++;
      exp_pc      = boot_addr;
      fetch_model = boot_addr;
      q_count     = 0;
    end else if (take_branch) begin
      epoch++;
      exp_pc      = branch_pc & ~32'd3;
      fetch_model = branch_pc & ~32'd3;
      q_count     = 0;
    end else begin
      if (rsp_live) begin
        q_count++;
        fetch_model = fetch_model + 32'd4;
      end
      if (popped) q_count--;
    end
    @(negedge clock);
    cyc++;
  endtask

  task automatic do_reset(input logic [31:0] addr, input int lat);
    reset        = 1'b1;
    boot_addr    = addr;
    take_branch  = 1'b0;
    branch_pc    = '0;
    stall_fetch  = 1'b0;
    icache_ready = 1'b1;
    lat_lo       = lat;
    lat_hi       = lat;
    repeat (2) step();
    reset = 1'b0;
    acc_log.delete();
    pop_log.delete();
    first_valid_cyc = -1;
  endtask

  initial begin
    int c0;
    reset            = 1'b1;
    boot_addr        = 32'h1000;
    take_branch      = 1'b0;
    branch_pc        = '0;
    stall_fetch      = 1'b0;
    icache_ready     = 1'b1;
    icache_rsp_valid = 1'b0;
    icache_rsp_data  = '0;
    @(negedge clock);

    // Boot with a 2-cycle cache
    do_reset(32'h1000, 2);
    c0 = cyc;
    step();
    check("boot_req_valid", obs_req_valid, 1);
    check("boot_req_addr", obs_req_addr, 32'h1000);
    repeat (20) step();
    check("boot_latency", first_valid_cyc, c0 + 3);
`ifdef FETCH_LINE_BUFFER_EN
    check("boot_second_req", acc_log[1], 32'h1010);
`else
    check("boot_second_req", acc_log[1], 32'h1004);
`endif
    check("boot_pop_count", pop_log.size() >= 4, 1);
    for (int i = 0; i < 4; i++) check("boot_pop_pc", pop_log[i], 32'h1000 + 32'(4 * i));

    // Full queue under a decode stall, then drain with the cache blocked
    do_reset(32'h2000, 2);
    stall_fetch = 1'b1;
    repeat (40) step();
    check("full_req_valid", obs_req_valid, 0);
    check("full_dec_valid", obs_valid, 1);
    stall_fetch  = 1'b0;
    icache_ready = 1'b0;
    repeat (4) step();
    check("drain_four", pop_log.size(), 4);
    repeat (4) step();
    check("drain_exact", pop_log.size(), 4);
    check("drain_last_pc", pop_log[3], 32'h200C);

    // Redirect while the request is outstanding
    do_reset(32'h1000, 3);
    step();
    take_branch = 1'b1;
    branch_pc   = 32'h2002;
    step();
    take_branch = 1'b0;
    repeat (15) step();
    check("redir_wait_req", acc_log[1], 32'h2000);
    check("redir_wait_pop", pop_log[0], 32'h2000);

    // Redirect in the same cycle as the response
    do_reset(32'h1000, 2);
    step();
    step();
    take_branch = 1'b1;
    branch_pc   = 32'h3000;
    step();
    take_branch = 1'b0;
    step();
    check("redir_rsp_req_valid", obs_req_valid, 1);
    check("redir_rsp_req_addr", obs_req_addr, 32'h3000);
    repeat (10) step();
    check("redir_rsp_pop", pop_log[0], 32'h3000);

    // Overlapping push and pop with a partly filled queue
    do_reset(32'h4000, 1);
    stall_fetch = 1'b1;
    repeat (6) step();
    stall_fetch = 1'b0;
    repeat (14) step();
    check("pp_pop_count", pop_log.size() >= 6, 1);
    for (int i = 0; i < 6; i++) check("pp_order", pop_log[i], 32'h4000 + 32'(4 * i));

    // Address wrap across the top of memory
    do_reset(32'hFFFF_FFFC, 1);
    repeat (12) step();
    check("wrap_req0", acc_log[0], 32'hFFFF_FFFC);
    check("wrap_req1", acc_log[1], 32'h0000_0000);
    check("wrap_pop0", pop_log[0], 32'hFFFF_FFFC);
    check("wrap_pop1", pop_log[1], 32'h0000_0000);

    // Randomized traffic
    lat_lo = 1;
    lat_hi = 4;
    for (int n = 0; n < 4000; n++) begin
      stall_fetch  = ($urandom_range(0, 9) < 3);
      icache_ready = ($urandom_range(0, 9) < 7);
      take_branch  = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 3))
        0:       branch_pc = $urandom;
        1:       branch_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        2:       branch_pc = exp_pc + ($urandom & 32'h1F);
        default: branch_pc = $urandom & 32'hFFFF;
      endcase
      reset = ($urandom_range(0, 499) == 0);
      if (reset) boot_addr = $urandom & ~32'd3;
      step();
      reset = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised fetch stage that follows the fixed single-entry fetch stage. It keeps a `QUEUE_DEPTH`-entry instruction queue between the instruction cache and decode, so decode stalls no longer block cache requests. An optional line buffer serves consecutive instructions from the last returned cache line without a new request. Branch redirects flush the queue and squash any in-flight cache response. The block sits between the core's redirect/stall logic and the instruction cache request/response port.

## Interface
- `PC_WIDTH`, 32: program counter width in bits.
- `INSTR_WIDTH`, 32: instruction width. Instructions are 4-byte aligned.
- `LINE_WIDTH`, 128: cache line width. Must be a power-of-two multiple of `INSTR_WIDTH`.
- `QUEUE_DEPTH`, 4: instruction queue entries. Must be a power of two and at least 2.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `boot_addr` in `PC_WIDTH`: fetch start address, sampled while `reset` is high.
- `take_branch` in 1: redirect request.
- `branch_pc` in `PC_WIDTH`: redirect target. Bits [1:0] are ignored and treated as 0.
- `stall_fetch` in 1: decode cannot accept an instruction this cycle.
- `decode_instr_valid` out 1: queue head is valid.
- `decode_instr_data` out `INSTR_WIDTH`: queue head instruction.
- `decode_instr_pc` out `PC_WIDTH`: queue head PC.
- `icache_req_valid` out 1: cache lookup request.
- `icache_req_addr` out `PC_WIDTH`: lookup address; equals `fetch_pc`.
- `icache_ready` in 1: cache accepts a request this cycle.
- `icache_rsp_valid` in 1: response strobe, one cycle.
- `icache_rsp_data` in `LINE_WIDTH`: full line of the requested address.

## Operation
- Internal state:
  - `fetch_pc`: next PC to fetch.
  - Circular queue of {pc, instr} with head pointer, tail pointer and count.
  - FSM with states FETCH, WAIT and DRAIN.
  - Line buffer: tag = `fetch_pc[PC_WIDTH-1:log2(LINE_WIDTH/8)]`, plus data and a valid bit.
- Word select: `word = pc[log2(LINE_WIDTH/8)-1:2]`. The selected instruction is `line[INSTR_WIDTH*word +: INSTR_WIDTH]`.
- FETCH state:
  - Line-buffer hit (valid, tag match, queue not full): push the word from the line buffer, `fetch_pc += 4`, no cache request, stay in FETCH.
  - Otherwise, when the queue is not full: drive `icache_req_valid`=1. On `icache_ready`=1 the request is accepted and the FSM moves to WAIT.
  - At most one request is outstanding.
- WAIT state, on `icache_rsp_valid`:
  - Push the selected word with pc=`fetch_pc`.
  - Load the line buffer.
  - `fetch_pc += 4`.
  - Go to FETCH.
  - A free queue slot is guaranteed because a request is only issued when the queue is not full.
- Pop: the head is consumed when `decode_instr_valid && !stall_fetch`. A push and a pop in the same cycle leave the count unchanged.
- Redirect (`take_branch`=1) has priority over every other event in that cycle:
  - Queue flushed (count 0 next cycle).
  - Any same-cycle push or pop is dropped.
  - `fetch_pc` <= `branch_pc & ~3`.
  - Next state: from WAIT with no response this cycle, go to DRAIN. From WAIT with a response this cycle, the response is discarded and the FSM goes to FETCH. From FETCH, stay in FETCH. From DRAIN, stay in DRAIN.
  - The line buffer is preserved; instruction memory is read-only.
- DRAIN state: `icache_req_valid`=0. The next `icache_rsp_valid` is discarded without loading the line buffer, and the FSM goes to FETCH.
- PC arithmetic wraps modulo 2^`PC_WIDTH`. Wraps across a line boundary force a tag miss.

## Timing
- Reset state: `fetch_pc`=`boot_addr`, queue empty, line buffer invalid, FSM in FETCH.
- Outputs during reset: `decode_instr_valid`=0, `decode_instr_data`=0, `decode_instr_pc`=0, `icache_req_valid`=0.
- `reset` asserted mid-operation abandons any outstanding request. A response arriving after reset deassertion while in FETCH is ignored.
- First request is issued in the first cycle after `reset` deasserts.
- Queue write is registered. An instruction pushed in cycle N is visible at decode in cycle N+1.
- Miss path: request accepted in cycle R, response in cycle R+k (k ≥ 1), `decode_instr_valid` in cycle R+k+1.
- Line-buffer hits sustain 1 instruction per cycle while the queue is not full.
- Queue outputs are driven directly from the head register. The decode path has no combinational dependence on cache inputs.

## Configuration
- `FETCH_LINE_BUFFER_EN`:
  - Defined: line buffer present, with hit behaviour as above.
  - Undefined: no line-buffer storage. Every instruction requires a cache request, so sustained throughput is 1 instruction per (k+1) cycles. All other behaviour is unchanged.

## Test plan
- Boot: reset with `boot_addr`=0x1000, cache with 2-cycle latency, no stall. Requests at 0x1000, then 0x1010 (with line buffer) or 0x1004 (without). Decode sees PCs 0x1000, 0x1004, 0x1008, 0x100C in order with correct words.
- Full queue: `QUEUE_DEPTH`=4, hold `stall_fetch`=1. Exactly 4 entries are pushed, then `icache_req_valid` stays 0. Releasing the stall drains 4 entries in 4 cycles.
- Redirect in WAIT: request 0x1000 outstanding, `take_branch`=1 with `branch_pc`=0x2002. The 0x1000 response is dropped and the next request is 0x2000. Decode never sees 0x1000.
- Redirect coincident with response: `take_branch` in the cycle of `icache_rsp_valid`. The response is discarded, no DRAIN, next request at the target.
- Push and pop in the same cycle with count=2: count stays 2 and order is preserved.
- Wrap: `boot_addr`=0xFFFFFFFC. Next PC is 0x00000000 with a new line request, no false hit.
